// File: rtl/act_stream_tx.sv
// Activation stream transmitter: ReLU + requantize + saturate psums into 8-bit activations, 2-stage pipeline.
// Optional build macro ACT_ROUND_EN selects round-to-nearest instead of truncation.
module act_stream_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [9:0]  map_size_i,
  input  logic [3:0]  shift_i,
  input  logic        psum_valid_i,
  input  logic [23:0] psum_i,
  output logic        psum_ready_o,
  output logic        act_valid_o,
  output logic [7:0]  act_result_o,
  output logic [9:0]  act_result_address_o,
  output logic        act_last_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned PW = 24;
  localparam int unsigned XW = PW + 1;
  localparam int unsigned AW = 10;
  localparam int unsigned RW = 8;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   n_q;
  logic [SW-1:0]   shift_q;
  logic [AW-1:0]   cnt_q;
  logic [AW-1:0]   cnt_nxt;
  logic            start_ok;
  logic            xfer;
  logic            in_last;

  logic            s1_valid;
  logic [PW-1:0]   s1_psum;
  logic [AW-1:0]   s1_addr;
  logic            s1_last;

  logic [XW-1:0]   mag;
  logic [XW-1:0]   rnd;
  logic [XW-1:0]   shifted;
  logic [RW-1:0]   res;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok)   state_d = RUN;
      RUN:     if (in_last)    state_d = DRAIN;
      DRAIN:   if (act_last_o) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // State-decoded controls and handshake
  always_comb begin
    psum_ready_o = 1'b0;
    busy_o       = 1'b0;
    start_ok     = 1'b0;
    case (state_q)
      IDLE:  start_ok     = start_i && (map_size_i != '0);
      RUN: begin
        psum_ready_o = 1'b1;
        busy_o       = 1'b1;
      end
      DRAIN: busy_o       = 1'b1;
      default: ;
    endcase
    cnt_nxt = cnt_q + AW'(1);
    xfer    = psum_ready_o && psum_valid_i;
    in_last = xfer && (cnt_nxt == n_q);
  end

  // Requantize: shift in 25 bits so the rounding add cannot overflow, then clamp
  always_comb begin
    mag = {1'b0, s1_psum};
    rnd = '0;
`ifdef ACT_ROUND_EN
    if (shift_q != '0) rnd = XW'(1) << (shift_q - SW'(1));
`endif
    shifted = (mag + rnd) >> shift_q;
    if (s1_psum[PW-1])            res = '0;
    else if (shifted > XW'(255))  res = RW'(255);
    else                          res = shifted[RW-1:0];
  end

  // Map configuration, input counter and pipeline stages
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q                  <= '0;
      shift_q              <= '0;
      cnt_q                <= '0;
      s1_valid             <= 1'b0;
      s1_psum              <= '0;
      s1_addr              <= '0;
      s1_last              <= 1'b0;
      act_valid_o          <= 1'b0;
      act_result_o         <= '0;
      act_result_address_o <= '0;
      act_last_o           <= 1'b0;
      done_o               <= 1'b0;
    end else begin
      if (start_ok) begin
        n_q     <= map_size_i;
        shift_q <= shift_i;
        cnt_q   <= '0;
      end else if (xfer) begin
        cnt_q   <= cnt_nxt;
      end
      s1_valid             <= xfer;
      s1_psum              <= xfer ? psum_i : '0;
      s1_addr              <= xfer ? cnt_nxt : '0;
      s1_last              <= in_last;
      act_valid_o          <= s1_valid;
      act_result_o         <= s1_valid ? res : '0;
      act_result_address_o <= s1_valid ? s1_addr : '0;
      act_last_o           <= s1_valid && s1_last;
      done_o               <= (state_q == DRAIN) && act_last_o;
    end
  end

endmodule

// File: tb/tb_act_stream_tx.sv
// Testbench for act_stream_tx: directed and randomized maps checked cycle by cycle against a timeline model.
module tb_act_stream_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [9:0]  map_size_i;
  logic [3:0]  shift_i;
  logic        psum_valid_i;
  logic [23:0] psum_i;
  logic        psum_ready_o;
  logic        act_valid_o;
  logic [7:0]  act_result_o;
  logic [9:0]  act_result_address_o;
  logic        act_last_o;
  logic        busy_o;
  logic        done_o;

  act_stream_tx dut (
    .clk                  (clk),
    .rst                  (rst),
    .start_i              (start_i),
    .map_size_i           (map_size_i),
    .shift_i              (shift_i),
    .psum_valid_i         (psum_valid_i),
    .psum_i               (psum_i),
    .psum_ready_o         (psum_ready_o),
    .act_valid_o          (act_valid_o),
    .act_result_o         (act_result_o),
    .act_result_address_o (act_result_address_o),
    .act_last_o           (act_last_o),
    .busy_o               (busy_o),
    .done_o               (done_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // Reference requantization straight from the arithmetic definition
  function automatic int ref_act(input int p, input int sh);
    longint v;
    if (p < 0) return 0;
    v = longint'(p);
`ifdef ACT_ROUND_EN
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
    v = v / (longint'(1) << sh);
    return (v > 255) ? 255 : int'(v);
  endfunction

  // Timeline model: expected outputs scheduled into future cycle slots
  bit m_run = 0, m_drain = 0;
  int m_cnt = 0, m_n = 0, m_sh = 0;
  bit sv[8], slast[8], sdone[8];
  int sres[8], saddr[8];
  int k, kk;
  bit last_now;

  always @(negedge clk) begin
    k = cyc % 8;
    check("psum_ready", int'(psum_ready_o), int'(m_run));
    check("busy", int'(busy_o), int'(m_run || m_drain));
    check("act_valid", int'(act_valid_o), int'(sv[k]));
    check("act_result", int'(act_result_o), sres[k]);
    check("act_addr", int'(act_result_address_o), saddr[k]);
    check("act_last", int'(act_last_o), int'(slast[k]));
    check("done", int'(done_o), int'(sdone[k]));
    last_now = slast[k];
    sv[k] = 0; sres[k] = 0; saddr[k] = 0; slast[k] = 0; sdone[k] = 0;
    if (rst) begin
      m_run = 0; m_drain = 0; m_cnt = 0;
      for (int i = 0; i < 8; i++) begin
        sv[i] = 0; sres[i] = 0; saddr[i] = 0; slast[i] = 0; sdone[i] = 0;
      end
    end else begin
      if (last_now) m_drain = 0;
      if (!m_run && !m_drain && start_i && map_size_i != 10'd0) begin
        m_run = 1; m_cnt = 0; m_n = int'(map_size_i); m_sh = int'(shift_i);
      end else if (m_run && psum_valid_i) begin
        m_cnt++;
        kk = (cyc + 2) % 8;
        sv[kk]    = 1;
        sres[kk]  = ref_act(int'($signed(psum_i)), m_sh);
        saddr[kk] = m_cnt;
        slast[kk] = (m_cnt == m_n);
        if (m_cnt == m_n) begin
          sdone[(cyc + 3) % 8] = 1;
          m_run = 0; m_drain = 1;
        end
      end
    end
    cyc++;
  end

  int vq[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int rand_psum();
    case ($urandom % 4)
      0: return -int'($urandom_range(1, 8388608));
      1: return int'($urandom_range(0, 300));
      2: return int'($urandom_range(0, 8388607));
      default: return 8388607;
    endcase
  endfunction

  // mode 0: back-to-back, 1: alternate valid, 2: random gaps; poke: stray start while running
  task automatic run_map(input int n, input int sh, input int mode, input bit poke);
    int sent = 0;
    int ci = 0;
    bit v;
    start_i = 1; map_size_i = 10'(n); shift_i = 4'(sh); psum_valid_i = 0;
    tick();
    start_i = 0;
    while (sent < n) begin
      v = (mode == 0) || (mode == 1 && ci % 2 == 0) || (mode == 2 && ($urandom % 2) == 1);
      psum_valid_i = v;
      if (v) begin
        psum_i = 24'((vq.size() > 0) ? vq.pop_front() : rand_psum());
        sent++;
      end else begin
        psum_i = 24'($urandom);
      end
      start_i    = poke && (ci == 2);
      map_size_i = 10'd7;
      ci++;
      tick();
    end
    psum_valid_i = 0; start_i = 0;
    tick(); tick();
  endtask

  initial begin
    rst = 1; start_i = 0; map_size_i = 0; shift_i = 0; psum_valid_i = 0; psum_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    for (int i = 1; i <= 16; i++) vq.push_back(i);
    run_map(16, 0, 0, 0);

    vq.push_back(-5); vq.push_back(300); vq.push_back(255);
    run_map(3, 0, 0, 0);
    vq.push_back(1000);
    run_map(1, 2, 0, 0);

    vq.push_back(3);
    run_map(1, 1, 0, 0);
    vq.push_back(8388607);
    run_map(1, 15, 0, 0);

    run_map(4, 0, 1, 0);

    // zero-size start is ignored
    start_i = 1; map_size_i = 10'd0; shift_i = 4'd3;
    tick();
    start_i = 0;
    repeat (3) tick();

    // mid-map reset after 5 transfers
    start_i = 1; map_size_i = 10'd16; shift_i = 4'd0;
    tick();
    start_i = 0;
    for (int i = 0; i < 5; i++) begin
      psum_valid_i = 1; psum_i = 24'(i + 100);
      tick();
    end
    psum_valid_i = 0; rst = 1; start_i = 1; map_size_i = 10'd9;
    tick();
    rst = 0; start_i = 0;
    tick();
    run_map(2, 0, 0, 0);

    for (int m = 0; m < 20; m++)
      run_map(int'($urandom_range(1, 40)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 2)), bit'($urandom % 2));

    repeat (6) tick();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/act_stream_tx.md
ACT_STREAM_TX -- requirements
Module: act_stream_tx

Interface
REQ-001 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start_i  input  1  one-cycle pulse that begins one feature map.
REQ-004 SHALL have port map_size_i  input  10  element count N of the map (1..1023), sampled on an accepted start_i.
REQ-005 SHALL have port shift_i  input  4  requantization right-shift (0..15), sampled on an accepted start_i.
REQ-006 SHALL have port psum_valid_i  input  1  psum_i is valid this cycle.
REQ-007 SHALL have port psum_i  input  24  signed accumulator value.
REQ-008 SHALL have port psum_ready_o  output  1  block accepts psum_i this cycle.
REQ-009 SHALL have port act_valid_o  output  1  act_result_o and act_result_address_o are valid.
REQ-010 SHALL have port act_result_o  output  8  unsigned activation result.
REQ-011 SHALL have port act_result_address_o  output  10  1-based element address.
REQ-012 SHALL have port act_last_o  output  1  marks element N, coincident with its act_valid_o.
REQ-013 SHALL have port busy_o  output  1  high in RUN or DRAIN.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse after the last element is emitted.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-016 SHALL move IDLE->RUN on start_i=1 with map_size_i!=0, latching N and shift.
REQ-017 SHALL ignore start_i in RUN or DRAIN, and ignore start_i with map_size_i==0 (stays IDLE, no done_o).
REQ-018 SHALL drive psum_ready_o=1 only in RUN; a transfer occurs when psum_valid_i and psum_ready_o are both 1.
REQ-019 SHALL ignore psum_valid_i outside RUN, with no state change.
REQ-020 SHALL keep an input counter 1..N; the transfer of element N moves RUN->DRAIN in the same cycle.
REQ-021 SHALL use a 2-stage pipeline: S1 registers psum and its address, S2 registers the result; a transfer at cycle t yields act_valid_o=1 at t+2.
REQ-022 SHALL emit output addresses strictly 1,2,..,N with no gaps, even when input valid gaps occur; act_valid_o=0 in cycles with no S2 data.
REQ-023 SHALL produce act_result_o as follows: psum<0 -> 0; else v = psum >>> shift, computed in 25 bits; v>255 -> 255; else v[7:0].
REQ-024 SHALL drive act_result_o, act_result_address_o and act_last_o to 0 whenever act_valid_o=0.
REQ-025 SHALL, in DRAIN, go to IDLE and pulse done_o=1 in the cycle after act_last_o=1.
REQ-026 SHALL accept a start_i in the same cycle done_o=1, since the FSM is already IDLE.

Reset
REQ-027 SHALL, on rst=1, force IDLE, clear counters and pipeline, and drop in-flight data.
REQ-028 SHALL hold psum_ready_o, act_valid_o, act_result_o, act_result_address_o, act_last_o, busy_o and done_o at 0 during and after reset.
REQ-029 SHALL give rst priority over start_i and psum transfers in the same cycle.
REQ-030 SHALL restart a map begun after a mid-map reset at address 1.

Configuration
REQ-031 SHALL, with macro ACT_ROUND_EN defined, round to nearest: add 1<<(shift-1) before shifting when shift>0, then saturate.
REQ-032 SHALL, without ACT_ROUND_EN, truncate (plain arithmetic shift), with latency and interface unchanged.

Verification
REQ-033 SHALL check reset: rst held 3 cycles -> all outputs 0, psum_ready_o=0.
REQ-034 SHALL check a full map: N=16, shift=0, psum 1..16 back-to-back -> act_result 1..16, addresses 1..16, each 2 cycles after its input; act_last_o with address 16; done_o the next cycle.
REQ-035 SHALL check ReLU and saturation: N=3, shift=0, psum -5, 300, 255 -> 0, 255, 255; then N=1, shift=2, psum 1000 -> 250.
REQ-036 SHALL check rounding: N=1, shift=1, psum 3 -> 2 with ACT_ROUND_EN, 1 without; psum 0x7FFFFF with shift=15 -> 255, no overflow.
REQ-037 SHALL check input gaps: N=4 with psum_valid_i toggling 1,0,1,0,... -> addresses 1..4 contiguous, act_valid_o low in gap cycles.
REQ-038 SHALL check mid-map reset: rst after 5 of 16 transfers -> outputs 0 next cycle, IDLE; a new start with N=2 emits addresses 1,2 and act_last_o on 2.
